// File: rtl/alu_issue_if.sv
// Handshake bundle between the issue stage, its upstream producer and the ALU.
// Valid/ready contract: a beat moves when valid&ready are both high on a rising edge;
// a producer holding valid=1 keeps its payload stable until the beat moves.
interface alu_issue_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_ctrl;
  logic [5:0]       in_funct;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [2:0]       out_aluop;
  logic             out_illegal;
  logic [1:0]       dbg_state;

  modport master (
    output in_valid, in_a, in_b, in_ctrl, in_funct, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_aluop, out_illegal, dbg_state
  );

  modport slave (
    input  in_valid, in_a, in_b, in_ctrl, in_funct, out_ready,
    output in_ready, out_valid, out_a, out_b, out_aluop, out_illegal, dbg_state
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes ctrl/funct into ALUop and registers operands behind a
// 2-entry skid buffer. Optional statistics counters are enabled by ALU_ISSUE_CNT_EN.
module alu_issue_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  alu_issue_if.slave io
`ifdef ALU_ISSUE_CNT_EN
  ,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] illegal_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_a_q;
  logic [WIDTH-1:0] out_b_q;
  logic [2:0]       out_aluop_q;
  logic             out_illegal_q;
  logic [WIDTH-1:0] skid_a_q;
  logic [WIDTH-1:0] skid_b_q;
  logic [2:0]       skid_aluop_q;
  logic             skid_illegal_q;

  logic [2:0] dec_aluop_d;
  logic       dec_illegal_d;
  logic       accept;
  logic       emit;

  assign accept = io.in_valid & in_ready_q;
  assign emit   = out_valid_q & io.out_ready;

  // Illegal encodings select ALUop 011, which the ALU evaluates to zero.
  always_comb begin
    dec_aluop_d   = 3'b011;
    dec_illegal_d = 1'b1;
    case (io.in_ctrl)
      2'b00: begin
        dec_aluop_d   = 3'b010;
        dec_illegal_d = 1'b0;
      end
      2'b01: begin
        dec_aluop_d   = 3'b110;
        dec_illegal_d = 1'b0;
      end
      2'b10: begin
        case (io.in_funct)
          6'b100000: begin dec_aluop_d = 3'b010; dec_illegal_d = 1'b0; end
          6'b100010: begin dec_aluop_d = 3'b110; dec_illegal_d = 1'b0; end
          6'b100100: begin dec_aluop_d = 3'b000; dec_illegal_d = 1'b0; end
          6'b100101: begin dec_aluop_d = 3'b001; dec_illegal_d = 1'b0; end
          6'b101010: begin dec_aluop_d = 3'b111; dec_illegal_d = 1'b0; end
          default:   begin dec_aluop_d = 3'b011; dec_illegal_d = 1'b1; end
        endcase
      end
      default: begin
        dec_aluop_d   = 3'b011;
        dec_illegal_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= EMPTY;
      in_ready_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      out_a_q        <= '0;
      out_b_q        <= '0;
      out_aluop_q    <= 3'b000;
      out_illegal_q  <= 1'b0;
      skid_a_q       <= '0;
      skid_b_q       <= '0;
      skid_aluop_q   <= 3'b000;
      skid_illegal_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            out_a_q       <= io.in_a;
            out_b_q       <= io.in_b;
            out_aluop_q   <= dec_aluop_d;
            out_illegal_q <= dec_illegal_d;
            out_valid_q   <= 1'b1;
            state_q       <= BUSY;
          end
        end
        BUSY: begin
          if (accept && emit) begin
            out_a_q       <= io.in_a;
            out_b_q       <= io.in_b;
            out_aluop_q   <= dec_aluop_d;
            out_illegal_q <= dec_illegal_d;
          end else if (accept) begin
            // Output reg is stalled, so the new op parks in the skid reg.
            skid_a_q       <= io.in_a;
            skid_b_q       <= io.in_b;
            skid_aluop_q   <= dec_aluop_d;
            skid_illegal_q <= dec_illegal_d;
            in_ready_q     <= 1'b0;
            state_q        <= FULL;
          end else if (emit) begin
            out_valid_q <= 1'b0;
            state_q     <= EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            out_a_q       <= skid_a_q;
            out_b_q       <= skid_b_q;
            out_aluop_q   <= skid_aluop_q;
            out_illegal_q <= skid_illegal_q;
            in_ready_q    <= 1'b1;
            state_q       <= BUSY;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= EMPTY;
        end
      endcase
    end
  end

  assign io.in_ready    = in_ready_q;
  assign io.out_valid   = out_valid_q;
  assign io.out_a       = out_a_q;
  assign io.out_b       = out_b_q;
  assign io.out_aluop   = out_aluop_q;
  assign io.out_illegal = out_illegal_q;
  assign io.dbg_state   = state_q;

`ifdef ALU_ISSUE_CNT_EN
  logic [CNT_W-1:0] issue_cnt_q;
  logic [CNT_W-1:0] illegal_cnt_q;

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_q   <= '0;
      illegal_cnt_q <= '0;
    end else if (emit) begin
      if (issue_cnt_q != '1) issue_cnt_q <= issue_cnt_q + CNT_W'(1);
      if (out_illegal_q && (illegal_cnt_q != '1)) illegal_cnt_q <= illegal_cnt_q + CNT_W'(1);
    end
  end

  assign issue_cnt   = issue_cnt_q;
  assign illegal_cnt = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus randomized traffic checked by a
// depth-2 FIFO reference model with its own decode table.
module tb_alu_issue_stage;
  localparam int WIDTH = 32;
  localparam int CNT_W = 16;
  localparam int EW    = 2 * WIDTH + 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_if #(.WIDTH(WIDTH)) ifc();

`ifdef ALU_ISSUE_CNT_EN
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] illegal_cnt;
`endif

  alu_issue_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (ifc)
`ifdef ALU_ISSUE_CNT_EN
    ,
    .issue_cnt   (issue_cnt),
    .illegal_cnt (illegal_cnt)
`endif
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Expected entries packed as {a, b, illegal, aluop}, oldest first.
  logic [EW-1:0] exp_q[$];
  int model_issue   = 0;
  int model_illegal = 0;
  bit mon_en        = 1'b0;

  logic [5:0] legal_f[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  // Returns {illegal, aluop}.
  function automatic logic [3:0] ref_op(input logic [1:0] ctrl, input logic [5:0] funct);
    if (ctrl == 2'b00) return 4'b0_010;
    if (ctrl == 2'b01) return 4'b0_110;
    if (ctrl == 2'b11) return 4'b1_011;
    if (funct == 6'b100000) return 4'b0_010;
    if (funct == 6'b100010) return 4'b0_110;
    if (funct == 6'b100100) return 4'b0_000;
    if (funct == 6'b100101) return 4'b0_001;
    if (funct == 6'b101010) return 4'b0_111;
    return 4'b1_011;
  endfunction

  // ---------------- reference model: a 2-deep FIFO ----------------
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_issue   = 0;
      model_illegal = 0;
      mon_en        = 1'b1;
    end else begin : upd
      bit acc;
      bit emt;
      logic [EW-1:0] h;
      acc = (ifc.in_valid === 1'b1) && (exp_q.size() < 2);
      emt = (ifc.out_ready === 1'b1) && (exp_q.size() > 0);
      if (emt) begin
        h = exp_q.pop_front();
        if (model_issue < 65535) model_issue++;
        if (h[3] && model_illegal < 65535) model_illegal++;
      end
      if (acc) exp_q.push_back({ifc.in_a, ifc.in_b, ref_op(ifc.in_ctrl, ifc.in_funct)});
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      tests_run++;
      if (ifc.out_valid !== (exp_q.size() > 0)) begin
        tests_failed++;
        $display("FAIL sb_out_valid t=%0t got=%b exp=%b", $time, ifc.out_valid, exp_q.size() > 0);
      end
      tests_run++;
      if (ifc.in_ready !== (exp_q.size() < 2)) begin
        tests_failed++;
        $display("FAIL sb_in_ready t=%0t got=%b exp=%b", $time, ifc.in_ready, exp_q.size() < 2);
      end
      if (exp_q.size() > 0) begin
        tests_run++;
        if ({ifc.out_a, ifc.out_b, ifc.out_illegal, ifc.out_aluop} !== exp_q[0]) begin
          tests_failed++;
          $display("FAIL sb_data t=%0t got=%h exp=%h", $time,
                   {ifc.out_a, ifc.out_b, ifc.out_illegal, ifc.out_aluop}, exp_q[0]);
        end
      end
`ifdef ALU_ISSUE_CNT_EN
      tests_run++;
      if (issue_cnt !== CNT_W'(model_issue) || illegal_cnt !== CNT_W'(model_illegal)) begin
        tests_failed++;
        $display("FAIL sb_counters t=%0t got=%0d/%0d exp=%0d/%0d", $time,
                 issue_cnt, illegal_cnt, model_issue, model_illegal);
      end
`endif
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] ctrl, input logic [5:0] funct);
    ifc.in_a     = a;
    ifc.in_b     = b;
    ifc.in_ctrl  = ctrl;
    ifc.in_funct = funct;
  endtask

  task automatic drive_random_op();
    logic [1:0] c;
    logic [5:0] f;
    c = 2'($urandom_range(0, 3));
    if ($urandom_range(0, 9) < 7) f = legal_f[$urandom_range(0, 4)];
    else f = 6'($urandom_range(0, 63));
    drive_op($urandom, $urandom, c, f);
  endtask

  // Holds in_valid until the stage takes the op; returns at posedge+1.
  task automatic send_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] ctrl, input logic [5:0] funct);
    int  n;
    bit  done;
    drive_op(a, b, ctrl, funct);
    ifc.in_valid = 1'b1;
    done = 1'b0;
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      done = (ifc.in_ready === 1'b1);
      @(posedge clk); #1;
      n++;
    end
    ifc.in_valid = 1'b0;
    if (!done) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_timeout got=no_accept exp=accept within 50 cycles");
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    ifc.in_valid = 1'b0;
    ifc.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    tests_run += 6;
    if (ifc.out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid got=%b exp=0", ifc.out_valid); end
    if (ifc.in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_in_ready got=%b exp=1", ifc.in_ready); end
    if (ifc.out_a !== 32'd0) begin tests_failed++; $display("FAIL rst_out_a got=%h exp=0", ifc.out_a); end
    if (ifc.out_b !== 32'd0) begin tests_failed++; $display("FAIL rst_out_b got=%h exp=0", ifc.out_b); end
    if (ifc.out_aluop !== 3'b000) begin tests_failed++; $display("FAIL rst_aluop got=%b exp=000", ifc.out_aluop); end
    if (ifc.out_illegal !== 1'b0) begin tests_failed++; $display("FAIL rst_illegal got=%b exp=0", ifc.out_illegal); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic_add();
    ifc.out_ready = 1'b1;
    send_op(32'd1, 32'd2, 2'b00, 6'd0);
    @(negedge clk);
    tests_run += 5;
    if (ifc.out_valid !== 1'b1) begin tests_failed++; $display("FAIL add_valid got=%b exp=1", ifc.out_valid); end
    if (ifc.out_aluop !== 3'b010) begin tests_failed++; $display("FAIL add_aluop got=%b exp=010", ifc.out_aluop); end
    if (ifc.out_a !== 32'd1) begin tests_failed++; $display("FAIL add_a got=%h exp=1", ifc.out_a); end
    if (ifc.out_b !== 32'd2) begin tests_failed++; $display("FAIL add_b got=%h exp=2", ifc.out_b); end
    if (ifc.out_illegal !== 1'b0) begin tests_failed++; $display("FAIL add_illegal got=%b exp=0", ifc.out_illegal); end
    @(posedge clk); #1;
  endtask

  task automatic test_rtype();
    logic [5:0]  f_t[3]   = '{6'b101010, 6'b100101, 6'b111111};
    logic [31:0] a_t[3]   = '{32'd2, 32'd5, 32'hFFFF_FFFF};
    logic [31:0] b_t[3]   = '{32'd3, 32'hFFFF_FFF9, 32'd4};
    logic [2:0]  op_t[3]  = '{3'b111, 3'b001, 3'b011};
    logic        ill_t[3] = '{1'b0, 1'b0, 1'b1};
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_op(a_t[i], b_t[i], 2'b10, f_t[i]);
      @(negedge clk);
      tests_run += 4;
      if (ifc.out_aluop !== op_t[i]) begin tests_failed++; $display("FAIL rtype_aluop[%0d] got=%b exp=%b", i, ifc.out_aluop, op_t[i]); end
      if (ifc.out_illegal !== ill_t[i]) begin tests_failed++; $display("FAIL rtype_illegal[%0d] got=%b exp=%b", i, ifc.out_illegal, ill_t[i]); end
      if (ifc.out_a !== a_t[i]) begin tests_failed++; $display("FAIL rtype_a[%0d] got=%h exp=%h", i, ifc.out_a, a_t[i]); end
      if (ifc.out_b !== b_t[i]) begin tests_failed++; $display("FAIL rtype_b[%0d] got=%h exp=%h", i, ifc.out_b, b_t[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_full_backpressure();
    ifc.out_ready = 1'b0;
    send_op(32'h11, 32'h22, 2'b00, 6'd0);
    send_op(32'h33, 32'h44, 2'b01, 6'd0);
    drive_op(32'h55, 32'h66, 2'b10, 6'b100100);
    ifc.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run += 2;
      if (ifc.in_ready !== 1'b0) begin tests_failed++; $display("FAIL full_in_ready[%0d] got=%b exp=0", i, ifc.in_ready); end
      if (ifc.out_a !== 32'h11) begin tests_failed++; $display("FAIL full_hold_a[%0d] got=%h exp=11", i, ifc.out_a); end
      @(posedge clk); #1;
    end
    ifc.out_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (ifc.out_a !== 32'h11) begin tests_failed++; $display("FAIL order_x got=%h exp=11", ifc.out_a); end
    @(posedge clk); #1;
    @(negedge clk);
    tests_run += 2;
    if (ifc.out_a !== 32'h33) begin tests_failed++; $display("FAIL order_y got=%h exp=33", ifc.out_a); end
    if (ifc.in_ready !== 1'b1) begin tests_failed++; $display("FAIL drain_in_ready got=%b exp=1", ifc.in_ready); end
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    @(negedge clk);
    tests_run += 2;
    if (ifc.out_a !== 32'h55) begin tests_failed++; $display("FAIL order_z got=%h exp=55", ifc.out_a); end
    if (ifc.out_aluop !== 3'b000) begin tests_failed++; $display("FAIL order_z_aluop got=%b exp=000", ifc.out_aluop); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int n_ill;
    rst = 1'b1;
    ifc.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    ifc.out_ready = 1'b1;
    n_ill = 0;
    for (int i = 0; i < 8; i++) begin
      drive_random_op();
      ifc.in_valid = 1'b1;
      if (ref_op(ifc.in_ctrl, ifc.in_funct) >= 4'b1000) n_ill++;
      @(negedge clk);
      tests_run++;
      if (ifc.in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_in_ready[%0d] got=%b exp=1", i, ifc.in_ready); end
      if (i > 0) begin
        tests_run++;
        if (ifc.out_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_out_valid[%0d] got=%b exp=1", i, ifc.out_valid); end
      end
      @(posedge clk); #1;
    end
    ifc.in_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (ifc.out_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_last_valid got=%b exp=1", ifc.out_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++;
    if (ifc.out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_drained got=%b exp=0", ifc.out_valid); end
`ifdef ALU_ISSUE_CNT_EN
    tests_run += 2;
    if (issue_cnt !== CNT_W'(8)) begin tests_failed++; $display("FAIL b2b_issue_cnt got=%0d exp=8", issue_cnt); end
    if (illegal_cnt !== CNT_W'(n_ill)) begin tests_failed++; $display("FAIL b2b_illegal_cnt got=%0d exp=%0d", illegal_cnt, n_ill); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_random_traffic();
    for (int i = 0; i < 400; i++) begin
      ifc.in_valid  = ($urandom_range(0, 3) != 0);
      ifc.out_ready = ($urandom_range(0, 2) != 0);
      drive_random_op();
      @(posedge clk); #1;
    end
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_while_full();
    ifc.out_ready = 1'b0;
    send_op(32'hA1, 32'hB1, 2'b00, 6'd0);
    send_op(32'hA2, 32'hB2, 2'b11, 6'd0);
    @(negedge clk);
    tests_run++;
    if (ifc.in_ready !== 1'b0) begin tests_failed++; $display("FAIL rf_full got=%b exp=0", ifc.in_ready); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests_run += 3;
    if (ifc.out_valid !== 1'b0) begin tests_failed++; $display("FAIL rf_out_valid got=%b exp=0", ifc.out_valid); end
    if (ifc.in_ready !== 1'b1) begin tests_failed++; $display("FAIL rf_in_ready got=%b exp=1", ifc.in_ready); end
    if (ifc.out_a !== 32'd0) begin tests_failed++; $display("FAIL rf_out_a got=%h exp=0", ifc.out_a); end
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      tests_run++;
      if (ifc.out_valid !== 1'b0) begin tests_failed++; $display("FAIL rf_dropped[%0d] got=%b exp=0", i, ifc.out_valid); end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;
    drive_op(32'd0, 32'd0, 2'b00, 6'd0);
    test_reset();
    test_basic_add();
    test_rtype();
    test_full_backpressure();
    test_back_to_back();
    test_random_traffic();
    test_reset_while_full();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
